// File: rtl/tlb_unit.sv
// Fully associative TLB with miss-signalling FSM (IDLE/SIGNAL/WAIT) and round-robin refill.
// Optional feature macro: TLB_FLUSH_EN adds the tlb_flush port (invalidate all entries).
module tlb_unit #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        supervisor_mode,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_pc,
  output logic [31:0] paddr,
  output logic        hit,
  output logic        stall,
  output logic        TLB_MISS,
  output logic [31:0] TLB_PC_REG,
  output logic [31:0] TLB_ADDR_REG,
  input  logic        IRET,
  input  logic        tlb_wr_en,
  input  logic [19:0] tlb_wr_vpn,
`ifdef TLB_FLUSH_EN
  input  logic [19:0] tlb_wr_ppn,
  input  logic        tlb_flush
`else
  input  logic [19:0] tlb_wr_ppn
`endif
);

  localparam int unsigned PW = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, SIGNAL, WAIT} state_t;

  state_t            state;
  logic [ENTRIES-1:0] valid;
  logic [19:0]       vpn [ENTRIES];
  logic [19:0]       ppn [ENTRIES];
  logic [PW-1:0]     ptr;

  logic              u_hit;
  logic [19:0]       u_ppn;
  logic              wr_hit;
  logic [PW-1:0]     wr_idx;
  logic              user_miss;

  // VPNs are unique, so OR-combining the matching ppn is a plain mux.
  always_comb begin
    u_hit  = 1'b0;
    u_ppn  = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && vpn[i] == req_vaddr[31:12]) begin
        u_hit = 1'b1;
        u_ppn = u_ppn | ppn[i];
      end
      if (valid[i] && vpn[i] == tlb_wr_vpn) begin
        wr_hit = 1'b1;
        wr_idx = PW'(i);
      end
    end
  end

  assign user_miss = req_valid && !supervisor_mode && !u_hit;

  always_comb begin
    hit   = 1'b0;
    paddr = '0;
    if (req_valid) begin
      if (supervisor_mode) begin
        hit   = 1'b1;
        paddr = req_vaddr;
      end else if (u_hit) begin
        hit   = 1'b1;
        paddr = {u_ppn, req_vaddr[11:0]};
      end
    end
    stall = (state == SIGNAL) || user_miss;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      ptr          <= '0;
      TLB_MISS     <= 1'b0;
      TLB_PC_REG   <= '0;
      TLB_ADDR_REG <= '0;
    end else begin
      TLB_MISS <= 1'b0;
      case (state)
        IDLE: begin
          if (user_miss) begin
            TLB_PC_REG   <= req_pc;
            TLB_ADDR_REG <= req_vaddr;
            TLB_MISS     <= 1'b1;
            state        <= SIGNAL;
          end
        end
        SIGNAL: state <= WAIT;
        WAIT: begin
          if (IRET) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef TLB_FLUSH_EN
      if (tlb_flush) begin
        valid <= '0;
        ptr   <= '0;
      end else
`endif
      if (tlb_wr_en) begin
        if (wr_hit) begin
          ppn[wr_idx] <= tlb_wr_ppn;
        end else begin
          valid[ptr] <= 1'b1;
          vpn[ptr]   <= tlb_wr_vpn;
          ppn[ptr]   <= tlb_wr_ppn;
          ptr        <= ptr + 1'b1;
        end
      end
    end
  end

endmodule
